// File: rtl/estimador_func_matvec_sat.sv
// rtl/estimador_func_matvec_sat.sv - 3x3 signed fixed-point matrix-vector product with saturated rows
//
// Purpose: computes y = M*v, one multiply-accumulate per cycle (9 MAC cycles),
//          saturating each row result to W bits after dropping FRAC_BITS fraction bits.
//          Block-level ap_start/ap_done/ap_idle/ap_ready handshake.
// Ports:
//   ap_clk        clock, rising edge
//   ap_rst        asynchronous active-high reset
//   ap_start      run request, sampled only in IDLE
//   ap_ready      high in the IDLE cycle where ap_start is accepted (combinational)
//   ap_done       registered one-cycle pulse, results final
//   ap_idle       high while in IDLE
//   mat           9*W, element (r,c) at [(3r+c)*W +: W], captured on accept
//   vec           3*W, element c at [c*W +: W], captured on accept
//   y_out         3*W, row r at [r*W +: W]
//   y_out_ap_vld  equals ap_done
// Configuration macro: ESTIMADOR_MATVEC_ROUND_EN (round half toward +inf before the shift)

module estimador_func_matvec_sat #(
    parameter int W         = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_done,
    output logic             ap_idle,
    input  logic [9*W-1:0]   mat,
    input  logic [3*W-1:0]   vec,
    output logic [3*W-1:0]   y_out,
    output logic             y_out_ap_vld
);

    // Accumulator wide enough for three full 2W-bit products without wrapping.
    localparam int AW = 2*W + 2;

    localparam logic signed [AW-1:0] SMAX = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(W+3){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_row;
    logic [1:0]            r_col;
    logic signed [AW-1:0]  r_acc;
    logic signed [W-1:0]   r_m [9];
    logic signed [W-1:0]   r_v [3];
    logic [W-1:0]          r_y [3];
    logic                  r_done;

    logic                  w_accept;
    logic                  w_last_col;
    logic                  w_last_row;
    logic [3:0]            w_idx;
    logic signed [2*W-1:0] w_prod;
    logic signed [AW-1:0]  w_base;
    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_rsum;
    logic signed [AW-1:0]  w_shift;
    logic [W-1:0]          w_sat;

    assign w_last_col = (r_col == 2'd2);
    assign w_last_row = (r_row == 2'd2);
    assign w_idx      = {2'b00, r_row} * 4'd3 + {2'b00, r_col};
    assign w_prod     = r_m[w_idx] * r_v[r_col];

    // Column 0 starts a fresh row, so the previous row's sum is dropped here.
    assign w_base     = (r_col == 2'd0) ? '0 : r_acc;
    assign w_sum      = w_base + {{2{w_prod[2*W-1]}}, w_prod};

`ifdef ESTIMADOR_MATVEC_ROUND_EN
    localparam logic signed [AW-1:0] RND = {{(AW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    assign w_rsum     = w_sum + RND;
`else
    assign w_rsum     = w_sum;
`endif

    assign w_shift    = w_rsum >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[W-1:0];
        if (w_shift > SMAX) begin
            w_sat = {1'b0, {(W-1){1'b1}}};
        end else if (w_shift < SMIN) begin
            w_sat = {1'b1, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        ap_idle  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                w_accept = ap_start;
                if (ap_start) begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_row && w_last_col) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign ap_ready     = w_accept;
    assign ap_done      = r_done;
    assign y_out_ap_vld = r_done;
    assign y_out        = {r_y[2], r_y[1], r_y[0]};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < 9; i++) r_m[i] <= '0;
            for (int i = 0; i < 3; i++) r_v[i] <= '0;
            for (int i = 0; i < 3; i++) r_y[i] <= '0;
        end else begin
            // Done goes high exactly for the DONE state cycle.
            r_done <= (r_state == S_MAC) && w_last_row && w_last_col;
            if (w_accept) begin
                for (int i = 0; i < 9; i++) r_m[i] <= mat[i*W +: W];
                for (int i = 0; i < 3; i++) r_v[i] <= vec[i*W +: W];
                r_row <= '0;
                r_col <= '0;
                r_acc <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_sum;
                if (w_last_col) begin
                    r_y[r_row] <= w_sat;
                    r_col      <= '0;
                    r_row      <= w_last_row ? 2'd0 : r_row + 2'd1;
                end else begin
                    r_col <= r_col + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_estimador_func_matvec_sat.sv
// tb/tb_estimador_func_matvec_sat.sv - directed self-checking bench for estimador_func_matvec_sat

module tb_estimador_func_matvec_sat;

    localparam int W = 32;

    logic           ap_clk;
    logic           ap_rst;
    logic           ap_start;
    logic           ap_ready;
    logic           ap_done;
    logic           ap_idle;
    logic [9*W-1:0] mat;
    logic [3*W-1:0] vec;
    logic [3*W-1:0] y_out;
    logic           y_out_ap_vld;

    int n_pass;
    int n_total;

    estimador_func_matvec_sat #(.W(32), .FRAC_BITS(16)) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .mat          (mat),
        .vec          (vec),
        .y_out        (y_out),
        .y_out_ap_vld (y_out_ap_vld)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    localparam logic [9*W-1:0] M_IDENT = {32'h0001_0000, 32'h0, 32'h0,
                                          32'h0, 32'h0001_0000, 32'h0,
                                          32'h0, 32'h0, 32'h0001_0000};

    // Accept at the current negedge, then observe 14 cycles (cycle 0 = accept).
    task automatic run_op(input logic [9*W-1:0] m, input logic [3*W-1:0] v,
                          output logic [3*W-1:0] y, output int ready_cnt, output int ready_cyc,
                          output int done_cnt, output int done_cyc, output int vld_cnt);
        ready_cnt = 0; ready_cyc = -1; done_cnt = 0; done_cyc = -1; vld_cnt = 0; y = '0;
        @(negedge ap_clk);
        mat = m; vec = v; ap_start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            #1;
            if (ap_ready) begin ready_cnt++; ready_cyc = k; end
            if (ap_done) begin done_cnt++; done_cyc = k; y = y_out; end
            if (y_out_ap_vld) vld_cnt++;
            @(negedge ap_clk);
            if (k == 0) begin
                ap_start = 1'b0;
                mat = {9{32'hDEAD_BEEF}};
                vec = {3{32'hCAFE_F00D}};
            end
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; mat = '0; vec = '0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_total++; if (ap_idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", ap_idle); else n_pass++;
        n_total++; if (ap_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", ap_done); else n_pass++;
        n_total++; if (y_out_ap_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", y_out_ap_vld); else n_pass++;
        n_total++; if (y_out !== '0) $display("FAIL reset_y got=%h exp=0", y_out); else n_pass++;
        n_total++; if (ap_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ap_ready); else n_pass++;
    endtask

    task automatic test_identity();
        logic [3*W-1:0] y, v;
        int rc, rcy, dc, dcy, vc;
        v = {32'h0003_0000, 32'hFFFE_0000, 32'h0001_8000};
        run_op(M_IDENT, v, y, rc, rcy, dc, dcy, vc);
        n_total++; if (y !== v) $display("FAIL ident_y got=%h exp=%h", y, v); else n_pass++;
        n_total++; if (dcy !== 10) $display("FAIL ident_done_cycle got=%0d exp=10", dcy); else n_pass++;
        n_total++; if (dc !== 1) $display("FAIL ident_done_count got=%0d exp=1", dc); else n_pass++;
        n_total++; if (vc !== 1) $display("FAIL ident_vld_count got=%0d exp=1", vc); else n_pass++;
        n_total++; if (rc !== 1 || rcy !== 0) $display("FAIL ident_ready got=%0d@%0d exp=1@0", rc, rcy); else n_pass++;
        n_total++; if (y_out !== v) $display("FAIL ident_hold got=%h exp=%h", y_out, v); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [3*W-1:0] y;
        int rc, rcy, dc, dcy, vc;
        run_op({9{32'h7FFF_0000}}, {3{32'h7FFF_0000}}, y, rc, rcy, dc, dcy, vc);
        n_total++; if (y !== {3{32'h7FFF_FFFF}}) $display("FAIL sat_pos got=%h exp=%h", y, {3{32'h7FFF_FFFF}}); else n_pass++;
        run_op({9{32'h7FFF_0000}}, {3{32'h8000_0000}}, y, rc, rcy, dc, dcy, vc);
        n_total++; if (y !== {3{32'h8000_0000}}) $display("FAIL sat_neg got=%h exp=%h", y, {3{32'h8000_0000}}); else n_pass++;
        n_total++; if (dcy !== 10) $display("FAIL sat_done_cycle got=%0d exp=10", dcy); else n_pass++;
    endtask

    task automatic test_rounding();
        logic [3*W-1:0] y, e;
        int rc, rcy, dc, dcy, vc;
`ifdef ESTIMADOR_MATVEC_ROUND_EN
        e = {32'h0, 32'h0, 32'h0000_0001};
`else
        e = {32'h0, 32'hFFFF_FFFF, 32'h0};
`endif
        run_op({32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_8000, 32'h0, 32'h0, 32'h0000_8000},
               {32'h0, 32'h0, 32'h0000_0001}, y, rc, rcy, dc, dcy, vc);
        n_total++; if (y !== e) $display("FAIL round_y got=%h exp=%h", y, e); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [3*W-1:0] y, v;
        int rc, rcy, dc, dcy, vc, seen;
        v = {32'h0005_0000, 32'h0004_0000, 32'h0002_0000};
        @(negedge ap_clk);
        mat = M_IDENT; vec = v; ap_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            if (k == 0) ap_start = 1'b0;
        end
        #1;
        n_total++; if (y_out[31:0] !== 32'h0002_0000) $display("FAIL mid_row0 got=%h exp=00020000", y_out[31:0]); else n_pass++;
        ap_rst = 1'b1;
        #1;
        n_total++; if (y_out !== '0) $display("FAIL mid_rst_y got=%h exp=0", y_out); else n_pass++;
        n_total++; if (ap_idle !== 1'b1) $display("FAIL mid_rst_idle got=%b exp=1", ap_idle); else n_pass++;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (ap_done) seen++;
            @(negedge ap_clk);
        end
        n_total++; if (seen !== 0) $display("FAIL mid_no_done got=%0d exp=0", seen); else n_pass++;
        v = {32'h0000_4000, 32'hFFFF_C000, 32'h0007_0000};
        run_op(M_IDENT, v, y, rc, rcy, dc, dcy, vc);
        n_total++; if (y !== v) $display("FAIL mid_rerun_y got=%h exp=%h", y, v); else n_pass++;
        n_total++; if (dcy !== 10) $display("FAIL mid_rerun_done got=%0d exp=10", dcy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [9*W-1:0] ms [3];
        logic [3*W-1:0] vs [3];
        logic [3*W-1:0] es [3];
        int acc_cyc [3];
        int n_acc, n_done;
        ms[0] = M_IDENT;
        vs[0] = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        es[0] = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        ms[1] = {9{32'h0001_0000}};
        vs[1] = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        es[1] = {3{32'h0006_0000}};
        ms[2] = {32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h0002_0000};
        vs[2] = {32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000};
        es[2] = {32'h0001_0000, 32'hFFFE_0000, 32'h0002_0000};
        n_acc = 0; n_done = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = -1;
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c == 0 || c == 11 || c == 22) begin
                mat = ms[c/11]; vec = vs[c/11];
            end else begin
                for (int j = 0; j < 9; j++) mat[j*W +: W] = $urandom;
                for (int j = 0; j < 3; j++) vec[j*W +: W] = $urandom;
            end
            if (c == 23) ap_start = 1'b0;
            #1;
            if (ap_ready) begin
                if (n_acc < 3) acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (ap_done) begin
                if (n_done < 3) begin
                    n_total++;
                    if (y_out !== es[n_done] || c !== 10 + 11*n_done)
                        $display("FAIL b2b_run%0d got=%h@%0d exp=%h@%0d", n_done, y_out, c, es[n_done], 10 + 11*n_done);
                    else n_pass++;
                end
                n_done++;
            end
            @(negedge ap_clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (acc_cyc[i] !== 11*i) $display("FAIL b2b_accept%0d got=%0d exp=%0d", i, acc_cyc[i], 11*i); else n_pass++;
        end
        n_total++; if (n_acc !== 3) $display("FAIL b2b_accept_count got=%0d exp=3", n_acc); else n_pass++;
        n_total++; if (n_done !== 3) $display("FAIL b2b_done_count got=%0d exp=3", n_done); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_identity();
        test_saturation();
        test_rounding();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
